// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S serial audio receiver producing left/right sample pairs
//
// Purpose: deserialises an I2S stream (MSB first, WS leading the slot MSB by
// one bit period) into DATA_WIDTH-bit left/right words. Words are
// left-justified: short slots are zero padded, bits beyond DATA_WIDTH are
// dropped.
//
// Ports:
//   serial_clk    bit clock, all state changes on its rising edge
//   reset         asynchronous active-low reset
//   word_select   I2S WS (0 = left slot, 1 = right slot)
//   sound_bit_in  serial data, MSB first
//   left_sample   last complete left word
//   right_sample  last complete right word
//   sample_valid  one-cycle pulse when a new left/right pair is presented
//   frame_error   one-cycle pulse on a slot whose length differs from SLOT_WIDTH
//   bit_counter   bits received so far in the current slot (saturates at 63)
//
// Configuration macro: I2S_RX_FRAME_CHECK_EN enables slot length checking;
// when undefined, frame_error is tied low and every right slot updates outputs.

module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  word_select,
  input  logic                  sound_bit_in,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  frame_error,
  output logic [5:0]            bit_counter
);

  if (DATA_WIDTH < 8 || DATA_WIDTH > 32 || SLOT_WIDTH < DATA_WIDTH || SLOT_WIDTH > 32)
  begin : g_param_check
    $error("i2s_receiver: illegal DATA_WIDTH/SLOT_WIDTH");
  end

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t                state;
  logic                  ws_d;
  logic                  ws_edge;
  logic                  update_ok;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [DATA_WIDTH-1:0] word;

  assign ws_edge = (word_select != ws_d);

  // Bit n of the slot lands at position DATA_WIDTH-1-n, which gives the
  // left-justified, zero-padded word directly; bits past DATA_WIDTH match no
  // position and are dropped.
  always_comb begin
    word = shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(bit_counter) == DATA_WIDTH - 1 - i) word[i] = sound_bit_in;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic slot_bad;
  logic frame_error_q;
  // Slot length includes the final bit sampled on the WS edge itself.
  assign slot_bad    = (({1'b0, bit_counter} + 7'd1) != 7'(SLOT_WIDTH));
  assign update_ok   = !slot_bad;
  assign frame_error = frame_error_q;
`else
  assign update_ok   = 1'b1;
  assign frame_error = 1'b0;
`endif

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      state        <= SYNC;
      ws_d         <= 1'b0;
      shift        <= '0;
      left_hold    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      bit_counter  <= '0;
`ifdef I2S_RX_FRAME_CHECK_EN
      frame_error_q <= 1'b0;
`endif
    end else begin
      ws_d         <= word_select;
      sample_valid <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      frame_error_q <= 1'b0;
`endif
      case (state)
        SYNC: begin
          // Only a 1->0 edge marks the start of a left slot.
          if (ws_edge && !word_select) begin
            state       <= LEFT;
            shift       <= '0;
            bit_counter <= '0;
          end
        end
        LEFT, RIGHT: begin
          if (!ws_edge) begin
            shift <= word;
            if (bit_counter != 6'd63) bit_counter <= bit_counter + 6'd1;
          end else begin
`ifdef I2S_RX_FRAME_CHECK_EN
            frame_error_q <= slot_bad;
`endif
            shift       <= '0;
            bit_counter <= '0;
            if (state == LEFT && word_select) begin
              left_hold <= word;
              state     <= RIGHT;
            end else if (state == RIGHT && !word_select) begin
              if (update_ok) begin
                left_sample  <= left_hold;
                right_sample <= word;
                sample_valid <= 1'b1;
              end
              state <= LEFT;
            end else begin
              // Edge direction disagrees with the slot we think we are in.
              state <= SYNC;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 24: captured sample width per channel, legal range 8..32.
REQ-002 Parameter SLOT_WIDTH, default 32: expected serial_clk periods per channel slot, legal range DATA_WIDTH..32.
REQ-003 serial_clk  input  1  single bit clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 word_select  input  1  I2S WS: 0 = left slot, 1 = right slot; changes one bit period before the slot MSB.
REQ-006 sound_bit_in  input  1  serial data, MSB first.
REQ-007 left_sample  output  DATA_WIDTH  last complete left word.
REQ-008 right_sample  output  DATA_WIDTH  last complete right word.
REQ-009 sample_valid  output  1  one-cycle pulse: new left/right pair present.
REQ-010 frame_error  output  1  one-cycle pulse: slot length not equal to SLOT_WIDTH.
REQ-011 bit_counter  output  6  bits received in the current slot (debug).

Function
REQ-012 The block SHALL register word_select into ws_d each rising edge; an edge is a rising edge where word_select != ws_d.
REQ-013 States SHALL be SYNC, LEFT, and RIGHT.
REQ-014 SYNC SHALL ignore data and leave LEFT on the first WS 1->0 edge; a 0->1 edge in SYNC SHALL be ignored.
REQ-015 On a non-edge cycle in LEFT or RIGHT, the block SHALL shift sound_bit_in into the shift register only while bit_counter < DATA_WIDTH.
REQ-016 On such a non-edge cycle, bit_counter SHALL increment and saturate at 63.
REQ-017 On an edge, the sampled bit SHALL be the final bit of the ending slot, subject to the same shift rule, and the slot length SHALL be bit_counter+1.
REQ-018 A slot shorter than DATA_WIDTH SHALL yield a left-justified word with zero LSB padding; bits beyond DATA_WIDTH SHALL be discarded.
REQ-019 Edge LEFT->RIGHT: the block SHALL latch the word into an internal left hold register, clear the shift register, set bit_counter to 0, and enter RIGHT.
REQ-020 Edge RIGHT->LEFT: the block SHALL load left_sample from the hold register and right_sample from the completed word in the same edge, set sample_valid=1 for exactly one cycle, set bit_counter to 0, and enter LEFT.
REQ-021 Latency: sample_valid SHALL be high during the cycle following the rising edge that samples the right-slot final bit.
REQ-022 left_sample and right_sample SHALL hold their values between sample_valid pulses.
REQ-023 A WS toggle at the same edge as the final slot bit SHALL be treated as an edge (REQ-017), never as an extra data bit.
REQ-024 A WS edge whose direction mismatches the state (e.g. 0->1 in RIGHT) SHALL return the block to SYNC without updating the outputs.

Reset
REQ-025 reset low SHALL asynchronously force left_sample=0, right_sample=0, sample_valid=0, frame_error=0, bit_counter=0, ws_d=0, an empty shift register, and state SYNC.
REQ-026 Reset mid-slot SHALL discard partial words; after release, no sample_valid SHALL occur before one complete left slot and one complete right slot following a WS 1->0 edge.

Configuration
REQ-027 Macro I2S_RX_FRAME_CHECK_EN defined: at every edge in LEFT or RIGHT, a slot length != SLOT_WIDTH SHALL pulse frame_error for one cycle.
REQ-028 With I2S_RX_FRAME_CHECK_EN defined, a short or long right slot SHALL also suppress that edge's sample_valid and output update.
REQ-029 Macro I2S_RX_FRAME_CHECK_EN undefined: frame_error SHALL be tied 0, no length comparison logic SHALL exist, and every RIGHT->LEFT edge SHALL update the outputs.

Verification
REQ-030 Reset, then WS 1->0, then a 32-bit left slot 0xABCDEF00 and a 32-bit right slot 0x12345600 -> left_sample=0xABCDEF, right_sample=0x123456, sample_valid one cycle after the right slot final bit.
REQ-031 The bench SHALL send 700 continuous bit periods of alternating frames -> sample_valid once per 64 clocks, every pair matching the transmitted data, frame_error never set.
REQ-032 With I2S_RX_FRAME_CHECK_EN, a right slot truncated to 30 bits -> frame_error pulse, no sample_valid, previous outputs held; the next good frame updates the outputs normally.
REQ-033 Assert reset for 3 clocks mid-left-slot -> all outputs 0 and state SYNC; the first sample_valid arrives only after the next full left+right pair.
REQ-034 DATA_WIDTH=16 with a left slot 0xFFFF0000 -> left_sample=0xFFFF with the trailing 16 bits ignored.
REQ-035 Start streaming with WS=1 right after reset -> the first 0->1 edge is ignored and capture begins at the first WS 1->0 edge.
